// File: rtl/wbdepp_bridge.sv
// Digilent DEPP (EPP) host port bridged to a single-transaction Wishbone pipelined master.
// The host reaches a byte-wide register file; a command write launches one WB read or write.
module wbdepp_bridge #(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_astb_n,
  input  logic          i_dstb_n,
  input  logic          i_write_n,
  input  logic [7:0]    i_depp,
  output logic [7:0]    o_depp,
  output logic          o_wait,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [DW-1:0] o_wb_data,
  input  logic          i_wb_ack,
  input  logic          i_wb_stall,
  input  logic          i_wb_err,
  input  logic [DW-1:0] i_wb_data,
  input  logic          i_int
);

  localparam int NB = DW / 8;
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, HOLD = 2'd2} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] astb_sr, dstb_sr, wrn_sr;
  logic [7:0]             depp_sr [SYNC_STAGES];
  logic                   astb_prev, dstb_prev;
  logic                   astb_s, dstb_s, wrn_s;
  logic [7:0]             depp_s;

  logic [7:0]    rp_q, cmd_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, rdata_q;
  logic          err_q, to_q, int_q;
  logic [TW-1:0] tcnt_q;

  logic        a_fall, d_fall, both_high, cmd_start, tmo_hit;
  logic        a_evt, d_evt, launch, bus_end, stat_rd, wait_d;
  logic [7:0]  rd_byte;
  logic [31:0] addr_ext, wdata_ext, rdata_ext, addr_wr, wdata_wr;

  // Strobes, direction and data share one synchroniser depth so they stay aligned.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      astb_sr   <= '0;
      dstb_sr   <= '0;
      wrn_sr    <= '0;
      astb_prev <= 1'b0;
      dstb_prev <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) depp_sr[i] <= '0;
    end else begin
      astb_sr    <= {astb_sr[SYNC_STAGES-2:0], i_astb_n};
      dstb_sr    <= {dstb_sr[SYNC_STAGES-2:0], i_dstb_n};
      wrn_sr     <= {wrn_sr[SYNC_STAGES-2:0], i_write_n};
      depp_sr[0] <= i_depp;
      for (int i = 1; i < SYNC_STAGES; i++) depp_sr[i] <= depp_sr[i-1];
      astb_prev  <= astb_s;
      dstb_prev  <= dstb_s;
    end
  end

  assign astb_s    = astb_sr[SYNC_STAGES-1];
  assign dstb_s    = dstb_sr[SYNC_STAGES-1];
  assign wrn_s     = wrn_sr[SYNC_STAGES-1];
  assign depp_s    = depp_sr[SYNC_STAGES-1];
  assign a_fall    = astb_prev & ~astb_s;
  assign d_fall    = dstb_prev & ~dstb_s;
  assign both_high = astb_s & dstb_s;
  assign cmd_start = ~wrn_s & (rp_q == 8'h08) & (depp_s[0] | depp_s[1]);
  assign tmo_hit   = (TIMEOUT != 0) && (32'(tcnt_q) == TIMEOUT - 1);

  // Registers narrower than 32 bits are zero-extended so absent bytes read as 0
  // and writes to them fall away on truncation.
  assign addr_ext  = 32'(addr_q);
  assign wdata_ext = 32'(wdata_q);
  assign rdata_ext = 32'(rdata_q);

  always_comb begin
    addr_wr  = addr_ext;
    wdata_wr = wdata_ext;
    addr_wr[{rp_q[1:0], 3'b000} +: 8]  = depp_s;
    wdata_wr[{rp_q[1:0], 3'b000} +: 8] = depp_s;
  end

  always_comb begin
    rd_byte = 8'h00;
    if (rp_q < 8'h04)       rd_byte = addr_ext[{rp_q[1:0], 3'b000} +: 8];
    else if (rp_q < 8'h08)  rd_byte = rdata_ext[{rp_q[1:0], 3'b000} +: 8];
    else if (rp_q == 8'h08) rd_byte = cmd_q;
    else if (rp_q == 8'h09) rd_byte = {4'b0000, int_q, to_q, err_q, state_q == BUS};
  end

  always_comb begin
    state_d = state_q;
    wait_d  = o_wait;
    a_evt   = 1'b0;
    d_evt   = 1'b0;
    launch  = 1'b0;
    bus_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (a_fall) begin
          a_evt   = 1'b1;
          state_d = HOLD;
        end else if (d_fall) begin
          d_evt = 1'b1;
          if (cmd_start) begin
            launch  = 1'b1;
            state_d = BUS;
          end else begin
            state_d = HOLD;
          end
        end
      end
      BUS: begin
        if (i_wb_ack || i_wb_err || tmo_hit) begin
          bus_end = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // o_wait is always raised for at least one cycle, even if the host let go early.
        if (o_wait && both_high) begin
          wait_d  = 1'b0;
          state_d = IDLE;
        end else begin
          wait_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign stat_rd = d_evt & wrn_s & (rp_q == 8'h09);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      o_wait   <= 1'b0;
      o_depp   <= '0;
      o_wb_cyc <= 1'b0;
      o_wb_stb <= 1'b0;
      o_wb_we  <= 1'b0;
      rp_q     <= '0;
      cmd_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      to_q     <= 1'b0;
      int_q    <= 1'b0;
      tcnt_q   <= '0;
    end else begin
      state_q <= state_d;
      o_wait  <= wait_d;

      if (i_int)        int_q <= 1'b1;
      else if (stat_rd) int_q <= 1'b0;
      if (stat_rd) to_q <= 1'b0;

      if (a_evt) begin
        if (!wrn_s) rp_q   <= depp_s;
        else        o_depp <= rp_q;
      end

      if (d_evt) begin
        if (wrn_s)              o_depp  <= rd_byte;
        else if (rp_q < 8'h04)  addr_q  <= addr_wr[AW-1:0];
        else if (rp_q < 8'h08)  wdata_q <= wdata_wr[DW-1:0];
        else if (rp_q == 8'h08) begin
          cmd_q <= depp_s & 8'h83;
          err_q <= 1'b0;
        end
      end

      if (launch) begin
        o_wb_cyc <= 1'b1;
        o_wb_stb <= 1'b1;
        o_wb_we  <= depp_s[0];
        tcnt_q   <= '0;
      end

      if (state_q == BUS) begin
        if (o_wb_stb && !i_wb_stall) o_wb_stb <= 1'b0;
        if (tcnt_q != '1) tcnt_q <= tcnt_q + 1'b1;
        if (bus_end) begin
          o_wb_cyc <= 1'b0;
          o_wb_stb <= 1'b0;
          if (i_wb_ack) begin
            if (!o_wb_we) rdata_q <= i_wb_data;
            if (cmd_q[7]) addr_q <= addr_q + AW'(NB);
          end else if (i_wb_err) begin
            err_q <= 1'b1;
          end else begin
            to_q <= 1'b1;
          end
        end
      end
    end
  end

  assign o_wb_addr = addr_q;
  assign o_wb_data = wdata_q;

endmodule

// File: tb/tb_wbdepp_bridge.sv
// Bench for wbdepp_bridge: a 32/32 and a 16/24 instance share the EPP host and WB slave,
// and both are compared against a byte-level register model.
module tb_wbdepp_bridge;

  localparam int DW0 = 32, AW0 = 32, DW1 = 16, AW1 = 24, TMO = 16;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        astb_n = 1'b1, dstb_n = 1'b1, write_n = 1'b1;
  logic [7:0]  depp = '0;
  logic        irq = 1'b0;
  logic        wb_ack = 1'b0, wb_stall = 1'b0, wb_err = 1'b0;
  logic [31:0] wb_rdata = '0;

  logic [7:0]  depp_o0, depp_o1;
  logic        wait0, cyc0, stb0, we0, wait1, cyc1, stb1, we1;
  logic [31:0] addr0, data0;
  logic [23:0] addr1;
  logic [15:0] data1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wbdepp_bridge #(.DW(DW0), .AW(AW0), .SYNC_STAGES(2), .TIMEOUT(TMO)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_astb_n(astb_n), .i_dstb_n(dstb_n),
    .i_write_n(write_n), .i_depp(depp), .o_depp(depp_o0), .o_wait(wait0),
    .o_wb_cyc(cyc0), .o_wb_stb(stb0), .o_wb_we(we0), .o_wb_addr(addr0),
    .o_wb_data(data0), .i_wb_ack(wb_ack), .i_wb_stall(wb_stall),
    .i_wb_err(wb_err), .i_wb_data(wb_rdata), .i_int(irq));

  wbdepp_bridge #(.DW(DW1), .AW(AW1), .SYNC_STAGES(2), .TIMEOUT(TMO)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_astb_n(astb_n), .i_dstb_n(dstb_n),
    .i_write_n(write_n), .i_depp(depp), .o_depp(depp_o1), .o_wait(wait1),
    .o_wb_cyc(cyc1), .o_wb_stb(stb1), .o_wb_we(we1), .o_wb_addr(addr1),
    .o_wb_data(data1), .i_wb_ack(wb_ack), .i_wb_stall(wb_stall),
    .i_wb_err(wb_err), .i_wb_data(wb_rdata[15:0]), .i_int(irq));

  // ---------------- reference model ----------------
  logic [31:0] m_addr [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_rdata [2];
  logic [7:0]  m_rp, m_cmd;
  bit          m_err, m_to, m_int;

  function automatic logic [31:0] wmask(int w);
    if (w >= 32) return 32'hFFFF_FFFF;
    return (32'h1 << w) - 32'h1;
  endfunction

  function automatic logic [31:0] put_byte(logic [31:0] v, int idx, logic [7:0] b, int w);
    logic [31:0] r;
    r = (v & ~(32'hFF << (8 * idx))) | (32'(b) << (8 * idx));
    return r & wmask(w);
  endfunction

  function automatic logic [7:0] get_byte(logic [31:0] v, int idx);
    logic [31:0] s;
    s = v >> (8 * idx);
    return s[7:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_addr[i] = '0; m_wdata[i] = '0; m_rdata[i] = '0;
    end
    m_rp = '0; m_cmd = '0; m_err = 0; m_to = 0; m_int = 0;
  endtask

  task automatic model_write(input logic [7:0] val);
    if (m_rp < 8'h04) begin
      m_addr[0] = put_byte(m_addr[0], int'(m_rp), val, AW0);
      m_addr[1] = put_byte(m_addr[1], int'(m_rp), val, AW1);
    end else if (m_rp < 8'h08) begin
      m_wdata[0] = put_byte(m_wdata[0], int'(m_rp) - 4, val, DW0);
      m_wdata[1] = put_byte(m_wdata[1], int'(m_rp) - 4, val, DW1);
    end else if (m_rp == 8'h08) begin
      m_cmd = val & 8'h83;
      m_err = 0;
    end
  endtask

  task automatic model_read(output logic [7:0] e0, output logic [7:0] e1);
    e0 = 8'h00; e1 = 8'h00;
    if (m_rp < 8'h04) begin
      e0 = get_byte(m_addr[0], int'(m_rp)); e1 = get_byte(m_addr[1], int'(m_rp));
    end else if (m_rp < 8'h08) begin
      e0 = get_byte(m_rdata[0], int'(m_rp) - 4); e1 = get_byte(m_rdata[1], int'(m_rp) - 4);
    end else if (m_rp == 8'h08) begin
      e0 = m_cmd; e1 = m_cmd;
    end else if (m_rp == 8'h09) begin
      e0 = {4'b0000, m_int, m_to, m_err, 1'b0}; e1 = e0;
      m_int = 0; m_to = 0;
    end
  endtask

  // mode: 0 = no response (timeout), 1 = ack, 2 = err
  task automatic model_cmd(input logic [7:0] val, input int mode, input logic [31:0] rdata);
    m_cmd = val & 8'h83;
    m_err = 0;
    if (val[1:0] != 2'b00) begin
      if (mode == 1) begin
        if (!val[0]) begin
          m_rdata[0] = rdata & wmask(DW0);
          m_rdata[1] = rdata & wmask(DW1);
        end
        if (val[7]) begin
          m_addr[0] = (m_addr[0] + 32'(DW0 / 8)) & wmask(AW0);
          m_addr[1] = (m_addr[1] + 32'(DW1 / 8)) & wmask(AW1);
        end
      end else if (mode == 2) begin
        m_err = 1;
      end else begin
        m_to = 1;
      end
    end
  endtask

  // ---------------- drivers ----------------
  int          cap_stb, cap_cyc;
  bit          cap_we, cap_wait_early, cap_tmo;
  logic [31:0] cap_a0, cap_d0;
  logic [23:0] cap_a1;
  logic [15:0] cap_d1;

  task automatic host_access(input bit is_addr, input bit is_wr, input logic [7:0] val,
                             output logic [7:0] rd0, output logic [7:0] rd1,
                             output int lat, output bit hs_tmo);
    int n;
    @(negedge clk);
    write_n = ~is_wr;
    depp    = val;
    @(negedge clk);
    if (is_addr) astb_n = 1'b0; else dstb_n = 1'b0;
    lat = 0;
    while (!wait0 && lat < 100) begin @(negedge clk); lat++; end
    rd0 = depp_o0;
    rd1 = depp_o1;
    astb_n = 1'b1;
    dstb_n = 1'b1;
    n = 0;
    while (wait0 && n < 100) begin @(negedge clk); n++; end
    hs_tmo = (lat >= 100) || (n >= 100);
  endtask

  task automatic reg_write(input logic [7:0] rp, input logic [7:0] val,
                           output int lat, output bit hs_tmo);
    logic [7:0] r0, r1;
    int  l;
    bit  t0, t1;
    host_access(1'b1, 1'b1, rp, r0, r1, l, t0);
    m_rp = rp;
    host_access(1'b0, 1'b1, val, r0, r1, lat, t1);
    model_write(val);
    hs_tmo = t0 | t1;
  endtask

  task automatic reg_read(input logic [7:0] rp, output logic [7:0] rd0,
                          output logic [7:0] rd1, output bit hs_tmo);
    logic [7:0] r0, r1;
    int  l;
    bit  t0, t1;
    host_access(1'b1, 1'b1, rp, r0, r1, l, t0);
    m_rp = rp;
    host_access(1'b0, 1'b0, 8'h00, rd0, rd1, l, t1);
    hs_tmo = t0 | t1;
  endtask

  // Command write to rp 0x08 (already selected) with a scripted WB slave response.
  task automatic wb_cmd(input logic [7:0] val, input int mode, input int stall_n,
                        input int ack_dly, input logic [31:0] rdata);
    int n, k;
    @(negedge clk);
    write_n = 1'b0;
    depp    = val;
    @(negedge clk);
    dstb_n = 1'b0;
    n = 0;
    while (!cyc0 && n < 50) begin @(negedge clk); n++; end
    cap_tmo = !cyc0;
    cap_we = we0; cap_a0 = addr0; cap_d0 = data0; cap_a1 = addr1; cap_d1 = data1;
    cap_stb = 0; cap_cyc = 0; cap_wait_early = 0;
    k = 0;
    while (cyc0 && k < 100) begin
      cap_cyc++;
      if (stb0) cap_stb++;
      if (wait0) cap_wait_early = 1;
      wb_stall = (k < stall_n);
      wb_ack   = (mode == 1) && (k == ack_dly);
      wb_err   = (mode == 2) && (k == ack_dly);
      wb_rdata = rdata;
      @(negedge clk);
      k++;
    end
    wb_stall = 1'b0; wb_ack = 1'b0; wb_err = 1'b0;
    n = 0;
    while (!wait0 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) cap_tmo = 1;
    dstb_n = 1'b1;
    n = 0;
    while (wait0 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) cap_tmo = 1;
    model_cmd(val, mode, rdata);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({cyc0, stb0, we0, wait0, depp_o0, addr0, data0} !== '0) begin
      errors++; $display("FAIL reset_in_dut0: got cyc=%b stb=%b we=%b wait=%b depp=%h addr=%h data=%h want all 0",
                         cyc0, stb0, we0, wait0, depp_o0, addr0, data0);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({cyc0, stb0, we0, wait0, depp_o0, addr0, data0} !== '0) begin
      errors++; $display("FAIL reset_out_dut0: got cyc=%b stb=%b we=%b wait=%b depp=%h addr=%h data=%h want all 0",
                         cyc0, stb0, we0, wait0, depp_o0, addr0, data0);
    end
    checks++;
    if ({cyc1, stb1, we1, wait1, depp_o1, addr1, data1} !== '0) begin
      errors++; $display("FAIL reset_out_dut1: got cyc=%b stb=%b we=%b wait=%b depp=%h addr=%h data=%h want all 0",
                         cyc1, stb1, we1, wait1, depp_o1, addr1, data1);
    end
  endtask

  task automatic test_addr_write();
    logic [7:0] bytes [4];
    int  lat;
    bit  t;
    bytes = '{8'h78, 8'h56, 8'h34, 8'h12};
    for (int i = 0; i < 4; i++) begin
      reg_write(8'(i), bytes[i], lat, t);
      checks++;
      if (lat !== 4 || t) begin
        errors++; $display("FAIL wait_latency[%0d]: got %0d cycles (stuck=%0b) want 4", i, lat, t);
      end
    end
    checks++;
    if (addr0 !== 32'h1234_5678) begin
      errors++; $display("FAIL addr_bytes_dut0: got %h want 12345678", addr0);
    end
    checks++;
    if (addr1 !== m_addr[1][23:0]) begin
      errors++; $display("FAIL addr_bytes_dut1: got %h want %h", addr1, m_addr[1][23:0]);
    end
  endtask

  task automatic test_wb_write();
    logic [7:0] bytes [4];
    logic [7:0] r0, r1;
    logic [31:0] ea0, ed0;
    logic [23:0] ea1;
    logic [15:0] ed1;
    int  lat;
    bit  t;
    bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    for (int i = 0; i < 4; i++) reg_write(8'(4 + i), bytes[i], lat, t);
    host_access(1'b1, 1'b1, 8'h08, r0, r1, lat, t);
    m_rp = 8'h08;
    ea0 = m_addr[0]; ed0 = m_wdata[0]; ea1 = m_addr[1][23:0]; ed1 = m_wdata[1][15:0];
    wb_cmd(8'h81, 1, 0, 3, 32'h0);
    checks++;
    if (cap_we !== 1'b1 || cap_a0 !== ea0 || cap_d0 !== ed0) begin
      errors++; $display("FAIL wb_write_dut0: got we=%b addr=%h data=%h want we=1 addr=%h data=%h",
                         cap_we, cap_a0, cap_d0, ea0, ed0);
    end
    checks++;
    if (cap_a1 !== ea1 || cap_d1 !== ed1) begin
      errors++; $display("FAIL wb_write_dut1: got addr=%h data=%h want addr=%h data=%h", cap_a1, cap_d1, ea1, ed1);
    end
    checks++;
    if (cap_stb !== 1 || cap_cyc !== 4 || cap_wait_early || cap_tmo) begin
      errors++; $display("FAIL wb_write_shape: got stb=%0d cyc=%0d early_wait=%0b stuck=%0b want stb=1 cyc=4 0 0",
                         cap_stb, cap_cyc, cap_wait_early, cap_tmo);
    end
    checks++;
    if (addr0 !== 32'h1234_567C || addr1 !== m_addr[1][23:0]) begin
      errors++; $display("FAIL autoinc: got %h/%h want 1234567c/%h", addr0, addr1, m_addr[1][23:0]);
    end
  endtask

  task automatic test_wb_read();
    logic [7:0] r0, r1, e0, e1;
    int  lat;
    bit  t;
    host_access(1'b1, 1'b1, 8'h08, r0, r1, lat, t);
    m_rp = 8'h08;
    wb_cmd(8'h02, 1, 2, 3, 32'hCAFE_F00D);
    checks++;
    if (cap_stb !== 3 || cap_we !== 1'b0 || cap_tmo) begin
      errors++; $display("FAIL wb_read_stall: got stb=%0d we=%b stuck=%0b want stb=3 we=0", cap_stb, cap_we, cap_tmo);
    end
    for (int i = 4; i <= 8; i++) begin
      reg_read(8'(i), r0, r1, t);
      model_read(e0, e1);
      checks++;
      if (r0 !== e0 || r1 !== e1 || t) begin
        errors++; $display("FAIL rdata_rp%0h: got %h/%h want %h/%h", i, r0, r1, e0, e1);
      end
    end
  endtask

  task automatic test_timeout();
    logic [7:0] r0, r1, e0, e1;
    int  lat;
    bit  t;
    host_access(1'b1, 1'b1, 8'h08, r0, r1, lat, t);
    m_rp = 8'h08;
    wb_cmd(8'h02, 0, 0, 0, 32'h0);
    checks++;
    if (cap_cyc !== TMO || cap_tmo) begin
      errors++; $display("FAIL timeout_len: got cyc=%0d stuck=%0b want %0d", cap_cyc, cap_tmo, TMO);
    end
    for (int i = 0; i < 2; i++) begin
      reg_read(8'h09, r0, r1, t);
      model_read(e0, e1);
      checks++;
      if (r0 !== e0 || r1 !== e1) begin
        errors++; $display("FAIL timeout_status[%0d]: got %h/%h want %h/%h", i, r0, r1, e0, e1);
      end
    end
  endtask

  task automatic test_err_int();
    logic [7:0] r0, r1, e0, e1;
    int  lat;
    bit  t;
    @(negedge clk); irq = 1'b1;
    @(negedge clk); irq = 1'b0;
    m_int = 1;
    host_access(1'b1, 1'b1, 8'h08, r0, r1, lat, t);
    m_rp = 8'h08;
    wb_cmd(8'h01, 2, 0, 1, 32'h0);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) reg_write(8'h08, 8'h00, lat, t);
      reg_read(8'h09, r0, r1, t);
      model_read(e0, e1);
      checks++;
      if (r0 !== e0 || r1 !== e1) begin
        errors++; $display("FAIL err_status[%0d]: got %h/%h want %h/%h", i, r0, r1, e0, e1);
      end
    end
  endtask

  task automatic test_early_release();
    logic [7:0] r0, r1, e0, e1;
    int  lat, hi;
    bit  t;
    @(negedge clk); write_n = 1'b0; depp = 8'h05;
    @(negedge clk); astb_n = 1'b0;
    @(negedge clk); astb_n = 1'b1;
    m_rp = 8'h05;
    hi = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (wait0) hi++;
    end
    checks++;
    if (hi !== 1) begin
      errors++; $display("FAIL early_release_pulse: got %0d cycles of wait want 1", hi);
    end
    host_access(1'b0, 1'b0, 8'h00, r0, r1, lat, t);
    model_read(e0, e1);
    checks++;
    if (r0 !== e0 || r1 !== e1) begin
      errors++; $display("FAIL early_release_rp: got %h/%h want %h/%h", r0, r1, e0, e1);
    end
  endtask

  task automatic test_width();
    logic [7:0] r0, r1, e0, e1;
    int  lat;
    bit  t;
    reg_write(8'h06, 8'h99, lat, t);
    checks++;
    if (data0 !== m_wdata[0] || data1 !== m_wdata[1][15:0]) begin
      errors++; $display("FAIL width_wdata: got %h/%h want %h/%h", data0, data1, m_wdata[0], m_wdata[1][15:0]);
    end
    reg_write(8'h03, 8'h77, lat, t);
    checks++;
    if (addr0 !== m_addr[0] || addr1 !== m_addr[1][23:0]) begin
      errors++; $display("FAIL width_addr: got %h/%h want %h/%h", addr0, addr1, m_addr[0], m_addr[1][23:0]);
    end
    reg_read(8'h03, r0, r1, t);
    model_read(e0, e1);
    checks++;
    if (r0 !== e0 || r1 !== e1) begin
      errors++; $display("FAIL width_read_rp3: got %h/%h want %h/%h", r0, r1, e0, e1);
    end
  endtask

  task automatic test_random();
    logic [7:0] r0, r1, e0, e1, rp, val, cmd;
    logic [31:0] ea0, ed0;
    int  lat, op, st;
    bit  t;
    for (int it = 0; it < 30; it++) begin
      op = $urandom_range(0, 3);
      case (op)
        0: begin
          rp  = 8'($urandom_range(0, 15));
          val = 8'($urandom_range(0, 255));
          if (rp == 8'h08) val = val & 8'h80;
          reg_write(rp, val, lat, t);
          checks++;
          if (addr0 !== m_addr[0] || addr1 !== m_addr[1][23:0] ||
              data0 !== m_wdata[0] || data1 !== m_wdata[1][15:0] || t) begin
            errors++; $display("FAIL rand_write[%0d] rp=%h: got a=%h/%h d=%h/%h want a=%h/%h d=%h/%h",
                               it, rp, addr0, addr1, data0, data1, m_addr[0], m_addr[1][23:0],
                               m_wdata[0], m_wdata[1][15:0]);
          end
        end
        1: begin
          rp = 8'($urandom_range(0, 15));
          reg_read(rp, r0, r1, t);
          model_read(e0, e1);
          checks++;
          if (r0 !== e0 || r1 !== e1 || t) begin
            errors++; $display("FAIL rand_read[%0d] rp=%h: got %h/%h want %h/%h", it, rp, r0, r1, e0, e1);
          end
        end
        2: begin
          host_access(1'b1, 1'b0, 8'h00, r0, r1, lat, t);
          checks++;
          if (r0 !== m_rp || r1 !== m_rp || t) begin
            errors++; $display("FAIL rand_rp_read[%0d]: got %h/%h want %h", it, r0, r1, m_rp);
          end
        end
        default: begin
          for (int b = 4; b < 8; b++) reg_write(8'(b), 8'($urandom_range(0, 255)), lat, t);
          host_access(1'b1, 1'b1, 8'h08, r0, r1, lat, t);
          m_rp = 8'h08;
          cmd = ($urandom_range(0, 1) != 0) ? 8'h81 : 8'h01;
          st  = $urandom_range(0, 2);
          ea0 = m_addr[0]; ed0 = m_wdata[0];
          wb_cmd(cmd, 1, st, st + $urandom_range(0, 3), 32'h0);
          checks++;
          if (cap_we !== 1'b1 || cap_a0 !== ea0 || cap_d0 !== ed0 || cap_stb !== st + 1 ||
              addr0 !== m_addr[0] || addr1 !== m_addr[1][23:0] || cap_tmo) begin
            errors++; $display("FAIL rand_wb[%0d]: got we=%b a=%h d=%h stb=%0d post=%h/%h want 1 %h %h %0d %h/%h",
                               it, cap_we, cap_a0, cap_d0, cap_stb, addr0, addr1, ea0, ed0, st + 1,
                               m_addr[0], m_addr[1][23:0]);
          end
        end
      endcase
    end
  endtask

  task automatic test_reset_mid_bus();
    logic [7:0] r0, r1, e0, e1;
    int  lat, n;
    bit  t;
    host_access(1'b1, 1'b1, 8'h08, r0, r1, lat, t);
    @(negedge clk); write_n = 1'b0; depp = 8'h02;
    @(negedge clk); dstb_n = 1'b0;
    n = 0;
    while (!cyc0 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (!cyc0 || !cyc1) begin
      errors++; $display("FAIL mid_bus_launch: got cyc=%b/%b want 1/1", cyc0, cyc1);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cyc0, stb0, we0, wait0, depp_o0, addr0, data0, cyc1, stb1, we1, wait1, depp_o1, addr1, data1} !== '0) begin
      errors++; $display("FAIL mid_bus_reset: got cyc=%b/%b stb=%b/%b addr=%h/%h want all 0",
                         cyc0, cyc1, stb0, stb1, addr0, addr1);
    end
    dstb_n = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 8; i <= 9; i++) begin
      reg_read(8'(i), r0, r1, t);
      model_read(e0, e1);
      checks++;
      if (r0 !== e0 || r1 !== e1 || t) begin
        errors++; $display("FAIL post_reset_rp%0h: got %h/%h want %h/%h", i, r0, r1, e0, e1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_addr_write();
    test_wb_write();
    test_wb_read();
    test_timeout();
    test_err_int();
    test_early_release();
    test_width();
    test_random();
    test_reset_mid_bus();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
